mult_4bit_seq: RTL and testbench

MULT_4BIT_SEQ -- requirements
Module: mult_4bit_seq

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_4bit_seq_fulladder.sv | 24 ++
 rtl/mult_4bit_seq.sv | 95 +++++++++
 tb/tb_mult_4bit_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the 4-bit sequential shift-add multiplier:
// operand width and FSM state encodings used by RTL and bench alike.
package mult_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mult_4bit_seq_fulladder.sv
// Combinational WIDTH-bit ripple-carry adder; carry out is kept so the
// multiplier never loses the top bit of a partial sum.
module fulladder
  import mult_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             carry
);

  logic cy;

  always_comb begin
    cy  = 1'b0;
    out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    carry = cy;
  end

endmodule

// File: rtl/mult_4bit_seq.sv
// Sequential 4x4 unsigned multiplier: one shift-add step per cycle, four steps,
// then a single-cycle done pulse with the registered 8-bit product.
module mult_4bit_seq
  import mult_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     acc_q;
  logic [1:0]           cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     add_sum;
  logic                 add_carry;
  logic [WIDTH:0]       ext_d;
  logic [WIDTH-1:0]     acc_d;
  logic [WIDTH-1:0]     mplier_d;

  fulladder u_add (
    .a     (acc_q),
    .b     (mcand_q),
    .out   (add_sum),
    .carry (add_carry)
  );

  // {carry, sum, multiplier} shifted right by one; the multiplier LSB falls off.
  always_comb begin
    ext_d    = mplier_q[0] ? {add_carry, add_sum} : {1'b0, acc_q};
    acc_d    = ext_d[WIDTH:1];
    mplier_d = {ext_d[0], mplier_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= {acc_d, mplier_d};
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult_4bit_seq.sv
// Bench for mult_4bit_seq: directed corner cases, random operands and an
// exhaustive back-to-back sweep, all checked against plain a*b arithmetic.
module tb_mult_4bit_seq;
  import mult_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int done_cnt  = 0;
  int cyc       = 0;

  logic [2*WIDTH-1:0] model_prod;
  logic [2*WIDTH-1:0] exp_q[$];
  bit                 mon_en  = 1'b0;
  int                 last_done = -1;

  mult_4bit_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int p;
    p = int'(x) * int'(y);
    return p[2*WIDTH-1:0];
  endfunction

  // scoreboard for the exhaustive sweep: each done pulse pops one expected product
  always @(negedge clk) begin
    if (mon_en && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sweep_extra_done", 16'(done), 16'd0);
      end else begin
        check("sweep_product", 16'(product), 16'(exp_q.pop_front()));
      end
      if (last_done >= 0) check("sweep_spacing", 16'(cyc - last_done), 16'd6);
      last_done = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    a_in  = 4'd7;
    b_in  = 4'd7;
    repeat (2) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_product", 16'(product), 16'd0);
    rst_n = 1'b1;
    start = 1'b0;
    model_prod = '0;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit glitch);
    logic [2*WIDTH-1:0] exp;
    int pulses0;
    exp = ref_mul(a, b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    pulses0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("calc_busy", 16'(busy), 16'd1);
      check("calc_done", 16'(done), 16'd0);
      check("calc_hold", 16'(product), 16'(model_prod));
      check("calc_state", 16'(dut.state_q), 16'(CALC));
      if (glitch && i == 1) begin
        a_in  = 4'd2;
        b_in  = 4'd2;
        start = 1'b1;
      end
      if (glitch && i == 2) start = 1'b0;
      @(negedge clk);
    end
    check("done_pulse", 16'(done), 16'd1);
    check("done_busy", 16'(busy), 16'd0);
    check("done_product", 16'(product), 16'(exp));
    model_prod = exp;
    @(negedge clk);
    check("after_done", 16'(done), 16'd0);
    check("after_product", 16'(product), 16'(exp));
    check("pulse_count", 16'(done_cnt - pulses0), 16'd1);
  endtask

  task automatic reset_mid_op();
    int pulses0;
    @(negedge clk);
    a_in  = 4'd9;
    b_in  = 4'd9;
    start = 1'b1;
    pulses0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_product", 16'(product), 16'd0);
    rst_n = 1'b1;
    model_prod = '0;
    repeat (6) @(negedge clk);
    check("abort_no_pulse", 16'(done_cnt - pulses0), 16'd0);
    check("abort_idle_busy", 16'(busy), 16'd0);
  endtask

  task automatic sweep_all();
    mon_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      a_in  = 4'(k >> 4);
      b_in  = 4'(k);
      start = 1'b1;
      exp_q.push_back(ref_mul(4'(k >> 4), 4'(k)));
      repeat (5) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("sweep_leftover", 16'(exp_q.size()), 16'd0);
    mon_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    model_prod = '0;
    do_reset();

    run_op(4'd15, 4'd15, 1'b0);
    run_op(4'd0, 4'd9, 1'b0);
    run_op(4'd13, 4'd1, 1'b0);
    run_op(4'd6, 4'd7, 1'b1);
    reset_mid_op();
    run_op(4'd3, 4'd5, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    sweep_all();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
